alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  requester n wants the shared ALU; held high until gntn is seen.
REQ-005 op0/op1  input  4, a0/a1  input  8, b0/b1  input  8  operation code (globals.vh ALU_* codes) and operands of requester n; stable while reqn is high.
REQ-006 gnt0, gnt1  output  1 each  operands of requester n are captured at this clock edge.
REQ-007 alu_op  output  4, alu_a  output  8, alu_b  output  8, alu_st_in  output  8  drive the external ALU instance.
REQ-008 alu_r  input  8, alu_st_out  input  8  ALU result and status (---SVNZC).
REQ-009 rsp_valid  output  1, rsp_id  output  1, rsp_r  output  8, rsp_st  output  8  registered response, owner id, result and status.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 st  output  8  committed status register (requester 0's register when ALU_ARB_PRIV_ST_EN is defined).
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, EXEC and HOLD.
REQ-014 IDLE: gnt0 and gnt1 are combinational, at most one is high, and neither is high outside IDLE.
REQ-015 IDLE grant rules: only one reqn high grants it; both high grant the requester not granted last (round-robin); no req keeps the state in IDLE.
REQ-016 On a grant edge, the block SHALL latch op, a, b and the id into internal registers, update the last-granted pointer and go to EXEC.
REQ-017 EXEC, exactly one cycle: alu_op, alu_a and alu_b come from the latched registers, and alu_st_in is the status register of the owning context.
REQ-018 On the EXEC edge, the block SHALL load alu_r into rsp_r and alu_st_out into rsp_st, commit alu_st_out to the status register of the owning context, and go to HOLD.
REQ-019 In IDLE, alu_op, alu_a, alu_b and alu_st_in SHALL still be driven from the latched registers (no X on the ALU inputs).
REQ-020 HOLD: rsp_valid=1, and rsp_id, rsp_r and rsp_st stay stable until an edge with rsp_ready=1, which clears rsp_valid and returns the state to IDLE.
REQ-021 Latency: a request granted in cycle k SHALL give rsp_valid=1 in cycle k+2; with rsp_ready tied high, each operation takes 3 cycles.
REQ-022 No new grant SHALL be issued before the response is accepted (a single operation in flight).
REQ-023 A requester that drops reqn while not granted loses nothing; the arbiter SHALL keep no pending memory of it.
REQ-024 Status written in EXEC SHALL be visible as alu_st_in to the next operation on the same context, e.g. carry chaining for ROR/ROL.

Reset
REQ-025 While reset=1 at a rising edge, the block SHALL go to IDLE with rsp_valid=0, rsp_id=0, rsp_r=0x00, rsp_st=0x00, status register(s)=0x00, and latched op/a/b=0.
REQ-026 After reset, the last-granted pointer SHALL be 1, so requester 0 wins the first tie.
REQ-027 Reset in EXEC or HOLD SHALL abort the operation: no status commit, and the pending response is discarded.
REQ-028 No gnt SHALL be asserted in a cycle where reset is high.

Configuration
REQ-029 The macro ALU_ARB_PRIV_ST_EN SHALL select the status model.
REQ-030 ALU_ARB_PRIV_ST_EN defined: two private status registers, one per requester; each operation reads and commits only its owner's register, and st shows requester 0's register.
REQ-031 ALU_ARB_PRIV_ST_EN undefined: one shared status register, used and updated by both requesters, and st shows that register.

Verification
REQ-032 After reset, req0=1, op=ALU_ADD, a=0x7F, b=0x01, rsp_ready=1 -> gnt0 in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_r=0x80, rsp_st=0x0C; st=0x0C.
REQ-033 ADD 0xFF+0x01 by req0, then ROR a=0x02 by req1 (shared) -> first response r=0x00, st=0x03; second response r=0x81, st=0x0C.
REQ-034 Same sequence as REQ-033 with ALU_ARB_PRIV_ST_EN defined -> second response r=0x01, st=0x00; st output=0x03.
REQ-035 req0 and req1 high continuously, rsp_ready=1 -> grants alternate 0,1,0,1, one every 3 cycles, and each rsp_id matches its grant.
REQ-036 rsp_ready=0 for 5 cycles during HOLD with req1 high -> rsp_* stable, no gnt1, busy=1; gnt1 comes the cycle after acceptance.
REQ-037 reset pulse during EXEC -> rsp_valid=0 and st=0x00 the next cycle; no response appears.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one external ALU between two requesters.
// Define ALU_ARB_PRIV_ST_EN for private per-requester status registers (default: one shared register).
module alu_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] op0,
    input  logic [3:0] op1,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [7:0] b0,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [7:0] alu_st_in,
    input  logic [7:0] alu_r,
    input  logic [7:0] alu_st_out,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_r,
    output logic [7:0] rsp_st,
    input  logic       rsp_ready,
    output logic [7:0] st,
    output logic       busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0] r_state;
    logic       r_last;
    logic       r_id;
    logic [3:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_rsp_id;
    logic [7:0] r_rsp_r;
    logic [7:0] r_rsp_st;
    logic       w_idle;
    logic       w_gnt0;
    logic       w_gnt1;
    logic [7:0] w_ctx_st;

    // Ties go to the requester not granted last; no grant while reset is asserted.
    assign w_idle = (r_state == S_IDLE) && !reset;
    assign w_gnt0 = w_idle && req0 && (!req1 || r_last);
    assign w_gnt1 = w_idle && req1 && (!req0 || !r_last);

`ifdef ALU_ARB_PRIV_ST_EN
    logic [7:0] r_st0;
    logic [7:0] r_st1;

    assign w_ctx_st = r_id ? r_st1 : r_st0;
    assign st       = r_st0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st0 <= '0;
            r_st1 <= '0;
        end else if (r_state == S_EXEC) begin
            if (r_id) r_st1 <= alu_st_out;
            else      r_st0 <= alu_st_out;
        end
    end
`else
    logic [7:0] r_st;

    assign w_ctx_st = r_st;
    assign st       = r_st;

    always_ff @(posedge clk) begin
        if (reset)                  r_st <= '0;
        else if (r_state == S_EXEC) r_st <= alu_st_out;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rsp_id <= 1'b0;
            r_rsp_r  <= '0;
            r_rsp_st <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_op    <= w_gnt1 ? op1 : op0;
                        r_a     <= w_gnt1 ? a1 : a0;
                        r_b     <= w_gnt1 ? b1 : b0;
                        r_id    <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_id <= r_id;
                    r_rsp_r  <= alu_r;
                    r_rsp_st <= alu_st_out;
                    r_state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_st_in = w_ctx_st;
    assign rsp_valid = (r_state == S_HOLD);
    assign rsp_id    = r_rsp_id;
    assign rsp_r     = r_rsp_r;
    assign rsp_st    = r_rsp_st;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural ALU (---SVNZC status)
// and a transaction-level reference model; honours ALU_ARB_PRIV_ST_EN like the design.
module tb_alu_arbiter;
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_ROL = 4'h5;
    localparam logic [3:0] ALU_ROR = 4'h6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] op0 = '0, op1 = '0;
    logic [7:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic       gnt0, gnt1;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_st_in, alu_r, alu_st_out;
    logic       rsp_valid, rsp_id;
    logic [7:0] rsp_r, rsp_st, st;
    logic       rsp_ready = 1'b1;
    logic       busy;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_st_in(alu_st_in),
        .alu_r(alu_r), .alu_st_out(alu_st_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_st(rsp_st),
        .rsp_ready(rsp_ready), .st(st), .busy(busy)
    );

    // Behavioural ALU: returns {status, result}; status = {3'b0, S, V, N, Z, C}.
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] st_in);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v, n, z, cin;
        cin = st_in[0];
        c = cin;
        v = 1'b0;
        r = a;
        s = '0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            ALU_SUB: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_ROL: begin r = {a[6:0], cin}; c = a[7]; v = r[7] ^ c; end
            ALU_ROR: begin r = {cin, a[7:1]}; c = a[0]; v = r[7] ^ c; end
            default: r = a;
        endcase
        n = r[7];
        z = (r == 8'h00);
        return {3'b000, n ^ v, v, n, z, c, r};
    endfunction

    assign {alu_st_out, alu_r} = alu_model(alu_op, alu_a, alu_b, alu_st_in);

    // Reference model state: one transaction in flight, its age in cycles since grant.
    bit          m_inflight;
    int unsigned m_age;
    bit          m_owner, m_last, m_rsp_id;
    logic [3:0]  m_op;
    logic [7:0]  m_a, m_b, m_rsp_r, m_rsp_st;
    logic [7:0]  m_st [2];

    int n_checks = 0;
    int n_pass   = 0;
    int obs_gnt  = -1;

    function automatic int ctx(input bit owner);
`ifdef ALU_ARB_PRIV_ST_EN
        return owner ? 1 : 0;
`else
        return (owner == owner) ? 0 : 0;
`endif
    endfunction

    function automatic void model_reset();
        m_inflight = 0; m_age = 0; m_owner = 0; m_last = 1; m_rsp_id = 0;
        m_op = '0; m_a = '0; m_b = '0; m_rsp_r = '0; m_rsp_st = '0;
        m_st[0] = '0; m_st[1] = '0;
    endfunction

    function automatic int exp_grant();
        if (reset || m_inflight) return -1;
        if (req0 && req1)        return m_last ? 0 : 1;
        if (req0)                return 0;
        if (req1)                return 1;
        return -1;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endfunction

    // One clock cycle: compare at the falling edge, then advance the model at the rising edge.
    task automatic step();
        int g, c;
        logic [15:0] res;
        @(negedge clk);
        g = exp_grant();
        obs_gnt = gnt0 ? 0 : (gnt1 ? 1 : -1);
        check("gnt0", 32'(gnt0), 32'(g == 0));
        check("gnt1", 32'(gnt1), 32'(g == 1));
        check("busy", 32'(busy), 32'(m_inflight));
        check("rsp_valid", 32'(rsp_valid), 32'(m_inflight && m_age >= 2));
        check("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
        check("rsp_r", 32'(rsp_r), 32'(m_rsp_r));
        check("rsp_st", 32'(rsp_st), 32'(m_rsp_st));
        check("st", 32'(st), 32'(m_st[0]));
        check("alu_op", 32'(alu_op), 32'(m_op));
        check("alu_a", 32'(alu_a), 32'(m_a));
        check("alu_b", 32'(alu_b), 32'(m_b));
        if (m_inflight && m_age == 1) check("alu_st_in", 32'(alu_st_in), 32'(m_st[ctx(m_owner)]));
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!m_inflight) begin
            if (g >= 0) begin
                m_op = (g == 1) ? op1 : op0;
                m_a  = (g == 1) ? a1 : a0;
                m_b  = (g == 1) ? b1 : b0;
                m_owner = (g == 1); m_last = (g == 1);
                m_inflight = 1; m_age = 1;
            end
        end else if (m_age == 1) begin
            c = ctx(m_owner);
            res = alu_model(m_op, m_a, m_b, m_st[c]);
            m_st[c] = res[15:8];
            m_rsp_r = res[7:0]; m_rsp_st = res[15:8]; m_rsp_id = m_owner;
            m_age = 2;
        end else if (rsp_ready) begin
            m_inflight = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; reset = 1;
        step(); step();
        reset = 0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_r", 32'(rsp_r), 32'h00);
        check("rst_rsp_st", 32'(rsp_st), 32'h00);
        check("rst_st", 32'(st), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_alu_ab", 32'({alu_op, alu_a, alu_b}), 32'h0);
    endtask

    task automatic drain();
        req0 = 0; req1 = 0; rsp_ready = 1;
        repeat (4) step();
    endtask

    // Issue one request and check its response against fixed expectations.
    task automatic run_txn(input bit sel, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] er, input logic [7:0] est);
        int kg;
        bit got;
        kg = -1; got = 0;
        rsp_ready = 1;
        if (sel) begin op1 = op; a1 = a; b1 = b; req1 = 1; end
        else     begin op0 = op; a0 = a; b0 = b; req0 = 1; end
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (obs_gnt == (sel ? 1 : 0)) begin
                kg = k;
                if (sel) req1 = 0; else req0 = 0;
            end
            if (m_inflight && m_age >= 2) begin
                check("txn_r", 32'(rsp_r), 32'(er));
                check("txn_st", 32'(rsp_st), 32'(est));
                check("txn_id", 32'(rsp_id), 32'(sel));
                check("txn_latency", 32'(k + 1 - kg), 32'd2);
                got = 1;
            end
        end
        if (!got) check("txn_timeout", 32'h0, 32'h1);
        req0 = 0; req1 = 0;
        step();
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, r, st;
    } vec_t;

    vec_t tbl [10];
    int   gk [$];
    int   gi [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Requester-0 operations from reset; status chains through the carry bit.
        tbl[0] = '{ALU_ADD, 8'h7F, 8'h01, 8'h80, 8'h0C};
        tbl[1] = '{ALU_ADD, 8'hFF, 8'h01, 8'h00, 8'h03};
        tbl[2] = '{ALU_ROR, 8'h02, 8'h00, 8'h81, 8'h0C};
        tbl[3] = '{ALU_SUB, 8'h10, 8'h20, 8'hF0, 8'h15};
        tbl[4] = '{ALU_ROL, 8'h80, 8'h00, 8'h01, 8'h19};
        tbl[5] = '{ALU_AND, 8'hF0, 8'h0F, 8'h00, 8'h03};
        tbl[6] = '{ALU_XOR, 8'hAA, 8'h55, 8'hFF, 8'h15};
        tbl[7] = '{ALU_ROR, 8'h01, 8'h00, 8'h80, 8'h15};
        tbl[8] = '{ALU_SUB, 8'h80, 8'h01, 8'h7F, 8'h18};
        tbl[9] = '{ALU_OR,  8'h00, 8'h00, 8'h00, 8'h02};

        reset = 1;
        @(posedge clk);
        #1;
        model_reset();

        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_txn(0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].st);
            check("tbl_st_out", 32'(st), 32'(tbl[i].st));
        end

        // Carry chaining across requesters: shared versus private status.
        do_reset();
        run_txn(0, ALU_ADD, 8'hFF, 8'h01, 8'h00, 8'h03);
`ifdef ALU_ARB_PRIV_ST_EN
        run_txn(1, ALU_ROR, 8'h02, 8'h00, 8'h01, 8'h00);
        check("chain_st_out", 32'(st), 32'h03);
`else
        run_txn(1, ALU_ROR, 8'h02, 8'h00, 8'h81, 8'h0C);
        check("chain_st_out", 32'(st), 32'h0C);
`endif

        // Both requesting continuously: alternating grants every 3 cycles.
        do_reset();
        op0 = ALU_ADD; a0 = 8'h11; b0 = 8'h22;
        op1 = ALU_SUB; a1 = 8'h40; b1 = 8'h05;
        req0 = 1; req1 = 1; rsp_ready = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (obs_gnt >= 0) begin gk.push_back(k); gi.push_back(obs_gnt); end
        end
        check("rr_count", 32'(gk.size()), 32'd4);
        for (int i = 0; i < gk.size() && i < 4; i++) begin
            check("rr_cycle", 32'(gk[i]), 32'(3 * i));
            check("rr_id", 32'(gi[i]), 32'(i % 2));
        end
        drain();

        // Back-pressure in HOLD with requester 1 waiting.
        do_reset();
        rsp_ready = 0;
        op0 = ALU_ADD; a0 = 8'h7F; b0 = 8'h01; req0 = 1;
        step();
        req0 = 0; op1 = ALU_SUB; a1 = 8'h05; b1 = 8'h03; req1 = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_r", 32'(rsp_r), 32'h80);
            check("hold_st", 32'(rsp_st), 32'h0C);
            check("hold_valid", 32'(rsp_valid), 32'h1);
            check("hold_busy", 32'(busy), 32'h1);
            check("hold_no_gnt1", 32'(obs_gnt == 1), 32'h0);
        end
        rsp_ready = 1;
        step();
        check("accept_no_gnt", 32'(obs_gnt == 1), 32'h0);
        step();
        check("gnt1_after_accept", 32'(obs_gnt == 1), 32'h1);
        req1 = 0;
        drain();

        // Reset during EXEC aborts the operation; no grant while reset is high.
        do_reset();
        rsp_ready = 1;
        op0 = ALU_ADD; a0 = 8'hFF; b0 = 8'h01; req0 = 1;
        step();
        req0 = 0; reset = 1;
        step();
        reset = 0;
        check("abort_valid", 32'(rsp_valid), 32'h0);
        check("abort_st", 32'(st), 32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_rsp", 32'(rsp_valid), 32'h0);
        end
        req1 = 1; reset = 1;
        step();
        check("gnt_in_reset", 32'(obs_gnt >= 0), 32'h0);
        reset = 0; req1 = 0;
        step();

        // Randomised traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (req0 && obs_gnt == 0) req0 = 0;
            if (req1 && obs_gnt == 1) req1 = 0;
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; op0 = 4'($urandom_range(0, 6)); a0 = 8'($urandom); b0 = 8'($urandom);
            end else if (req0 && $urandom_range(0, 15) == 0) begin
                req0 = 0;
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; op1 = 4'($urandom_range(0, 6)); a1 = 8'($urandom); b1 = 8'($urandom);
            end else if (req1 && $urandom_range(0, 15) == 0) begin
                req1 = 0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
